// File: rtl/data_memory_if.sv
// Core-side bus between the processor and data_memory: one 4-byte access
// per cycle, byte i of each transfer targets address+i.
interface data_memory_if;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic            mem_write_en;
  logic [0:3][7:0] mem_data_out;
  logic            mem_ready;

  modport master (
    output mem_addr, mem_data_in, mem_write_en,
    input  mem_data_out, mem_ready
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_write_en,
    output mem_data_out, mem_ready
  );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed data memory with optional clear-after-reset sweep, halt
// lock-out and a saturating count of committed writes.
module data_memory #(
  parameter int ADDR_BITS      = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  output logic [15:0] write_count,
  data_memory_if.slave bus
);

  localparam int SIZE = 1 << ADDR_BITS;

  typedef enum logic [1:0] {CLEAR, READY, HALT} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] clear_ptr;
  logic [ADDR_BITS-1:0] ea;
  logic [7:0]           storage [SIZE];
  logic                 commit;
  logic                 last_clear;
  logic                 unused_addr_bits;

  // Only the low address bits select storage; the rest alias.
  assign ea               = bus.mem_addr[ADDR_BITS-1:0];
  assign unused_addr_bits = ^bus.mem_addr[31:ADDR_BITS];

  assign commit     = (state == READY) && bus.mem_write_en && !halted;
  assign last_clear = (clear_ptr == ADDR_BITS'(SIZE - 4));
  assign bus.mem_ready = (state != CLEAR);

  always_comb begin
    state_next = state;
    unique case (state)
      CLEAR:   if (last_clear) state_next = READY;
      READY:   if (halted)     state_next = HALT;
      HALT:                    state_next = HALT;
      default:                 state_next = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= CLEAR_ON_RESET ? CLEAR : READY;
      clear_ptr   <= '0;
      write_count <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clear_ptr <= clear_ptr + ADDR_BITS'(4);
      if (commit && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
    end
  end

  // NOTE: storage has no reset branch so it maps onto RAM; zeroing is done
  // by the CLEAR sweep instead. Writes are held off while rst_b is low so
  // reset alone never disturbs contents.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 4; i++) begin
        if (state == CLEAR)
          storage[clear_ptr + ADDR_BITS'(i)] <= 8'h00;
        else if (commit)
          storage[ea + ADDR_BITS'(i)] <= bus.mem_data_in[i];
      end
    end
  end

  // Reads are combinational so a same-cycle write returns pre-write data.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.mem_data_out[i] = bus.mem_ready ? storage[ea + ADDR_BITS'(i)] : 8'h00;
    end
  end

endmodule
